// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory responder
// Purpose: access-width encoding (shared with the CPU control unit) and the
//          responder FSM state type.
// Ports:   none (package).
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'd0,
        MEM_HALF    = 2'd1,
        MEM_WORD    = 2'd2,
        MEM_ILLEGAL = 2'd3
    } mem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between CPU and data memory
// Purpose: groups the load/store request and response handshakes. Signal
//          suffixes are from the responder's point of view.
// Ports:   none; modport master = CPU side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_write_i;
    logic [1:0]  req_width_i;
    logic        req_sext_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_write_i, req_width_i, req_sext_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_write_i, req_width_i, req_sext_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for sub-word loads and stores
// Purpose: combinational; derives byte enables and replicated store data,
//          extracts and extends load data, and flags misaligned half/word.
// Ports:   width_i (access width), lane_i (addr[1:0]), wdata_i (LSB-aligned
//          store data), sext_i (sign-extend loads), rword_i (addressed word),
//          be_o (byte enables), wdata_o (lane-placed store data),
//          rdata_o (extended load data), misalign_o.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_width_e  width_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic        sext_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half accesses use lane bit 1 only; bit 0 is the misalign indicator.
    assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    assign half_sel = rword_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
        misalign_o = 1'b0;
        case (width_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            end
            MEM_HALF: begin
                misalign_o = lane_i[0];
                be_o       = 4'b0011 << {lane_i[1], 1'b0};
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{sext_i & half_sel[15]}}, half_sel};
            end
            MEM_WORD: begin
                misalign_o = (lane_i != 2'b00);
                be_o       = 4'b1111;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-modelling data-memory responder
// Purpose: accepts one load/store at a time, waits WAIT_CYCLES, performs the
//          access on a byte-enabled word array and returns data/error over
//          a held response handshake.
// Ports:   clk_i (rising edge), rst_i (async, active-high),
//          bus (dmem_responder_if.slave: request and response channels).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    mem_width_e  width_q, width_d;
    logic        sext_q, sext_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rword;
    logic [3:0]            be;
    logic [31:0]           wdata_sh;
    logic [31:0]           load_data;
    logic                  misalign;
    logic                  out_of_range;
    logic                  req_err;
    logic                  access_en;

    assign idx          = addr_q[ADDR_WIDTH+1:2];
    assign rword        = mem[idx];
    assign out_of_range = (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
    assign req_err      = (width_q == MEM_ILLEGAL) | misalign | out_of_range;

    dmem_lane_align u_align (
        .width_i    (width_q),
        .lane_i     (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .sext_i     (sext_q),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata_sh),
        .rdata_o    (load_data),
        .misalign_o (misalign)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            width_q <= MEM_BYTE;
            sext_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            width_q <= width_d;
            sext_q  <= sext_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Errored requests still pass through ST_WAIT for one cycle so the error
    // is decoded from registered fields; they leave without touching memory.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        width_d   = width_q;
        sext_d    = sext_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        access_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    write_d = bus.req_write_i;
                    width_d = mem_width_e'(bus.req_width_i);
                    sext_d  = bus.req_sext_i;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (req_err) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access_en = 1'b1;
                    err_d     = 1'b0;
                    rdata_d   = write_q ? 32'd0 : load_data;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Array is deliberately outside the reset domain: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (access_en && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if if2 ();
    dmem_responder_if if0 ();

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if2)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [4096];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic merr(input logic [31:0] a, input logic [1:0] w);
        return (w == 2'd3) || (w == 2'd1 && (a % 2) != 0) ||
               (w == 2'd2 && (a % 4) != 0) || (a >= 32'd4096);
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] w, input logic s);
        logic [31:0] v = 32'd0;
        int n = nbytes(w);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(a + i)]) << (8 * i));
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic mstore(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        for (int i = 0; i < nbytes(w); i++) ref_mem[12'(a + i)] = 8'(d >> (8 * i));
    endtask

    task automatic do_req(input logic wr, input logic [1:0] w, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        logic ok = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", 32'(if2.req_ready_o), 32'd1);
        if2.req_valid_i = 1'b1; if2.req_write_i = wr; if2.req_width_i = w;
        if2.req_sext_i  = s;    if2.req_addr_i  = a;  if2.req_wdata_i = d;
        @(posedge clk); #1;
        if2.req_valid_i = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            lat++;
            if (if2.rsp_valid_o) ok = 1'b1;
        end
        if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
        rd = if2.rsp_rdata_o;
        er = if2.rsp_err_o;
        for (int i = 0; i < hold; i++) begin
            // A clobbering store is offered while the response is stalled.
            if2.req_valid_i = 1'b1; if2.req_write_i = 1'b1; if2.req_width_i = 2'd2;
            if2.req_addr_i  = 32'd0; if2.req_wdata_i = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", 32'(if2.rsp_valid_o), 32'd1);
            chk("hold_rdata", if2.rsp_rdata_o, rd);
            chk("hold_err",   32'(if2.rsp_err_o), 32'(er));
            chk("hold_ready", 32'(if2.req_ready_o), 32'd0);
        end
        if2.req_valid_i = 1'b0;
        if2.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        if2.rsp_ready_i = 1'b0;
        chk("rsp_drop", 32'(if2.rsp_valid_o), 32'd0);
        chk("back_idle", 32'(if2.req_ready_o), 32'd1);
    endtask

    task automatic xact(input string tag, input logic wr, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er);
        int lat;
        logic        e_err = merr(a, w);
        logic [31:0] e_rd  = (wr || e_err) ? 32'd0 : mload(a, w, s);
        do_req(wr, w, s, a, d, hold, rd, er, lat);
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".err"},   32'(er), 32'(e_err));
        chk({tag, ".lat"},   32'(lat), e_err ? 32'd1 : 32'd3);
        if (wr && !e_err) mstore(a, w, d);
    endtask

    task automatic do_req0(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        logic ok = 1'b0;
        @(negedge clk);
        if0.req_valid_i = 1'b1; if0.req_write_i = wr; if0.req_width_i = 2'd2;
        if0.req_sext_i  = 1'b0; if0.req_addr_i  = a;  if0.req_wdata_i = d;
        @(posedge clk); #1;
        if0.req_valid_i = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            lat++;
            if (if0.rsp_valid_o) ok = 1'b1;
        end
        if (!ok) chk("rsp0_timeout", 32'd0, 32'd1);
        rd = if0.rsp_rdata_o;
        if0.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        if0.rsp_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] a;
        logic [1:0]  w;

        if2.req_valid_i = 0; if2.req_write_i = 0; if2.req_width_i = 0; if2.req_sext_i = 0;
        if2.req_addr_i  = 0; if2.req_wdata_i = 0; if2.rsp_ready_i = 0;
        if0.req_valid_i = 0; if0.req_write_i = 0; if0.req_width_i = 0; if0.req_sext_i = 0;
        if0.req_addr_i  = 0; if0.req_wdata_i = 0; if0.rsp_ready_i = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(if2.req_ready_o), 32'd1);
        chk("rst.rsp_valid", 32'(if2.rsp_valid_o), 32'd0);
        chk("rst.rdata",     if2.rsp_rdata_o,      32'd0);
        chk("rst.err",       32'(if2.rsp_err_o),   32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 16; i++) xact("fill", 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 0, rd, er);

        xact("sw10",   1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
        xact("lw10",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("lw10.const", rd, 32'hDEADBEEF);
        xact("sb13",   1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 0, rd, er);
        xact("lb13",   1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, rd, er);
        chk("lb13.const", rd, 32'hFFFFFF80);
        xact("lbu13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, rd, er);
        chk("lbu13.const", rd, 32'h00000080);
        xact("lw10b",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("lw10b.const", rd, 32'h80ADBEEF);
        xact("lh11",   1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, rd, er);
        xact("sw11",   1'b1, 2'd2, 1'b0, 32'h11, 32'h11111111, 0, rd, er);
        xact("w3",     1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, rd, er);
        xact("lw10c",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("lw10c.const", rd, 32'h80ADBEEF);
        xact("lw1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, rd, er);
        xact("sh1002", 1'b1, 2'd1, 1'b0, 32'h1002, 32'hBEEF, 0, rd, er);
        xact("lw0",    1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, rd, er);
        xact("hold",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, er);
        xact("lw0b",   1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, rd, er);

        // Reset while the store is still counting down in WAIT.
        @(negedge clk);
        if2.req_valid_i = 1'b1; if2.req_write_i = 1'b1; if2.req_width_i = 2'd2;
        if2.req_addr_i  = 32'h20; if2.req_wdata_i = 32'h12345678;
        @(posedge clk); #1;
        if2.req_valid_i = 1'b0;
        chk("wait.req_ready", 32'(if2.req_ready_o), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst.req_ready", 32'(if2.req_ready_o), 32'd1);
        chk("arst.rsp_valid", 32'(if2.rsp_valid_o), 32'd0);
        chk("arst.rdata",     if2.rsp_rdata_o,      32'd0);
        chk("arst.err",       32'(if2.rsp_err_o),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        xact("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, er);

        do_req0(1'b1, 32'h10, 32'hDEADBEEF, rd, lat);
        chk("w0.sw.lat", 32'(lat), 32'd1);
        do_req0(1'b0, 32'h10, 32'h0, rd, lat);
        chk("w0.lw.lat",   32'(lat), 32'd1);
        chk("w0.lw.rdata", rd, 32'hDEADBEEF);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + $urandom_range(0, 255);
                1:       a = $urandom | 32'h8000_0000;
                default: a = $urandom_range(0, 63);
            endcase
            w = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            xact("rnd", 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom,
                 ($urandom_range(0, 4) == 0) ? 2 : 0, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
